// File: rtl/wb_tube_dma_pkg.sv
// rtl/wb_tube_dma_pkg.sv - shared state enum, register map and helpers for the Tube DMA engine
package wb_tube_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_CYC1,
    ST_CYC2,
    ST_FIN
  } state_t;

  localparam logic [1:0] REG_ADDR_LO = 2'd0;
  localparam logic [1:0] REG_ADDR_HI = 2'd1;
  localparam logic [1:0] REG_COUNT   = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_DIR  = 1;
  localparam int CTRL_IE   = 2;
  localparam int CTRL_DONE = 15;

  localparam logic [15:0] TUBE_R3_IO_DEFAULT = 16'h0086;

  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  sel);
    byte_merge = {sel[1] ? new_val[15:8] : old_val[15:8],
                  sel[0] ? new_val[7:0]  : old_val[7:0]};
  endfunction

endpackage

// File: rtl/wb_tube_dma_regs.sv
// rtl/wb_tube_dma_regs.sv - Wishbone slave decode, register file and ack for the Tube DMA engine
// WB_TUBE_DMA_IRQ_EN: when defined, CTRL.IE is a real bit; otherwise it reads 0.
module wb_tube_dma_regs
  import wb_tube_dma_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_dat_i,
  output logic [15:0] s_dat_o,
  input  logic [1:0]  s_adr_i,
  input  logic [1:0]  s_sel_i,
  input  logic        s_we_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic        s_ack_o,
  input  state_t      state,
  input  logic        step,
  output logic [19:0] addr,
  output logic [15:0] count,
  output logic        en,
  output logic        dir,
  output logic        ie,
  output logic        done,
  output logic        start,
  output logic        abort_now,
  output logic        abort_hold
);

  logic        req, wr, wr_ctrl, abort_wr, bus, abort_pend;
  logic [15:0] rd_data;

  // The ack gates req so a held strobe never produces back-to-back acks.
  assign req      = s_cyc_i & s_stb_i & ~s_ack_o;
  assign wr       = req & s_we_i;
  assign wr_ctrl  = wr & (s_adr_i == REG_CTRL) & s_sel_i[0];
  assign bus      = (state == ST_CYC1) || (state == ST_CYC2);
  assign start    = wr_ctrl & s_dat_i[CTRL_EN] & (state == ST_IDLE);
  assign abort_wr = wr_ctrl & ~s_dat_i[CTRL_EN] & en;
  assign abort_now  = abort_wr & (state == ST_WAIT);
  assign abort_hold = abort_pend | (abort_wr & bus);

  always_comb begin
    rd_data = '0;
    case (s_adr_i)
      REG_ADDR_LO: rd_data = addr[15:0];
      REG_ADDR_HI: rd_data = {12'h000, addr[19:16]};
      REG_COUNT:   rd_data = count;
      default:     rd_data = {done, 12'h000, ie, dir, en};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_o    <= 1'b0;
      s_dat_o    <= '0;
      addr       <= '0;
      count      <= '0;
      en         <= 1'b0;
      dir        <= 1'b0;
      done       <= 1'b0;
      abort_pend <= 1'b0;
    end else begin
      s_ack_o <= req;
      if (req) s_dat_o <= rd_data;

      if (wr && !en) begin
        if (s_adr_i == REG_ADDR_LO) addr[15:0] <= byte_merge(addr[15:0], s_dat_i, s_sel_i);
        if (s_adr_i == REG_ADDR_HI && s_sel_i[0]) addr[19:16] <= s_dat_i[3:0];
        if (s_adr_i == REG_COUNT) count <= byte_merge(count, s_dat_i, s_sel_i);
      end
      if (step) begin
        addr  <= addr + 20'd1;
        count <= count - 16'd1;
      end

      if (wr_ctrl && !en) dir <= s_dat_i[CTRL_DIR];
      if (start) en <= 1'b1;
      if (abort_now || (step && abort_hold)) en <= 1'b0;

      // An abort landing mid-byte waits for the CYC2 ack so the byte is not torn.
      if (step) abort_pend <= 1'b0;
      else if (abort_wr && bus) abort_pend <= 1'b1;

      if (state == ST_FIN) begin
        en   <= 1'b0;
        done <= 1'b1;
      end else if (wr && s_adr_i == REG_CTRL && s_sel_i[1] && s_dat_i[CTRL_DONE]) begin
        done <= 1'b0;
      end
    end
  end

`ifdef WB_TUBE_DMA_IRQ_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ie <= 1'b0;
    else if (wr_ctrl) ie <= s_dat_i[CTRL_IE];
  end
`else
  assign ie = 1'b0;
`endif

endmodule

// File: rtl/wb_tube_dma.sv
// rtl/wb_tube_dma.sv - single-channel Tube R3 <-> memory DMA with Wishbone slave and master ports
// IE/irq exist only when WB_TUBE_DMA_IRQ_EN is defined (handled in wb_tube_dma_regs).
module wb_tube_dma
  import wb_tube_dma_pkg::*;
#(
  parameter logic [15:0] TUBE_R3_IO = TUBE_R3_IO_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] s_dat_i,
  output logic [15:0] s_dat_o,
  input  logic [1:0]  s_adr_i,
  input  logic [1:0]  s_sel_i,
  input  logic        s_we_i,
  input  logic        s_cyc_i,
  input  logic        s_stb_i,
  output logic        s_ack_o,
  input  logic [15:0] m_dat_i,
  output logic [15:0] m_dat_o,
  output logic [18:0] m_adr_o,
  output logic        m_tga_o,
  output logic [1:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  input  logic        drq,
  output logic        dack_b,
  output logic        irq
);

  localparam logic [18:0] IO_ADR = {4'h0, TUBE_R3_IO[15:1]};

  state_t      state_q, state_d;
  logic [19:0] addr;
  logic [15:0] count;
  logic        en, dir, ie, done, start, abort_now, abort_hold;
  logic        cyc1_ack, step, io_side;
  logic        cyc_d, stb_d, we_d, tga_d, dack_d;
  logic [1:0]  sel_d;
  logic [18:0] adr_d;
  logic [7:0]  rd_byte;

  assign cyc1_ack = (state_q == ST_CYC1) & m_stb_o & m_ack_i;
  assign step     = (state_q == ST_CYC2) & m_stb_o & m_ack_i;
  assign rd_byte  = m_sel_o[1] ? m_dat_i[15:8] : m_dat_i[7:0];
  assign irq      = done & ie;

  wb_tube_dma_regs u_regs (
    .clk        (clk),
    .rst        (rst),
    .s_dat_i    (s_dat_i),
    .s_dat_o    (s_dat_o),
    .s_adr_i    (s_adr_i),
    .s_sel_i    (s_sel_i),
    .s_we_i     (s_we_i),
    .s_cyc_i    (s_cyc_i),
    .s_stb_i    (s_stb_i),
    .s_ack_o    (s_ack_o),
    .state      (state_q),
    .step       (step),
    .addr       (addr),
    .count      (count),
    .en         (en),
    .dir        (dir),
    .ie         (ie),
    .done       (done),
    .start      (start),
    .abort_now  (abort_now),
    .abort_hold (abort_hold)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = (count != 16'd0) ? ST_WAIT : ST_FIN;
      ST_WAIT: begin
        if (abort_now || !en) state_d = ST_IDLE;
        else if (drq)         state_d = ST_CYC1;
      end
      ST_CYC1: if (cyc1_ack) state_d = ST_CYC2;
      ST_CYC2: begin
        if (step) begin
          if (abort_hold)              state_d = ST_IDLE;
          else if (count == 16'd1)     state_d = ST_FIN;
          else                         state_d = ST_WAIT;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Decoded from the next state so every master output can be a flop.
  always_comb begin
    cyc_d   = 1'b0;
    stb_d   = 1'b0;
    we_d    = 1'b0;
    tga_d   = 1'b0;
    sel_d   = 2'b00;
    adr_d   = '0;
    dack_d  = 1'b1;
    io_side = 1'b0;
    if (state_d == ST_CYC1 || state_d == ST_CYC2) begin
      io_side = (state_d == ST_CYC1) ? ~dir : dir;
      cyc_d   = 1'b1;
      dack_d  = 1'b0;
      // First cycle of CYC2 is the one-cycle strobe gap.
      stb_d   = (state_d == ST_CYC1) || (state_q == ST_CYC2);
      we_d    = (state_d == ST_CYC2);
      tga_d   = io_side;
      sel_d   = io_side ? 2'b01 : (addr[0] ? 2'b10 : 2'b01);
      adr_d   = io_side ? IO_ADR : addr[19:1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cyc_o <= 1'b0;
      m_stb_o <= 1'b0;
      m_we_o  <= 1'b0;
      m_tga_o <= 1'b0;
      m_sel_o <= 2'b00;
      m_adr_o <= '0;
      m_dat_o <= '0;
      dack_b  <= 1'b1;
    end else begin
      m_cyc_o <= cyc_d;
      m_stb_o <= stb_d;
      m_we_o  <= we_d;
      m_tga_o <= tga_d;
      m_sel_o <= sel_d;
      m_adr_o <= adr_d;
      dack_b  <= dack_d;
      if (cyc1_ack) m_dat_o <= {rd_byte, rd_byte};
    end
  end

endmodule
